// File: rtl/cnt_pwm_gen.sv
// cnt_pwm_gen: 16-cycle PWM driven by an external 4-bit down counter, with shadowed duty updates.
// Define PWM_SEQ_CHECK_EN to add the count-sequence checker and the ERR state.
module cnt_pwm_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt,
    input  logic [3:0] duty,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       pwm_out,
    output logic       period_done,
    output logic       seq_err
);
    // state | meaning
    // IDLE  | waiting for the first cnt==15, outputs held low
    // RUN   | producing PWM from the active duty
    // ERR   | count sequence broken, outputs low until reset (checker build only)
`ifdef PWM_SEQ_CHECK_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_ERR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_duty_act;
    logic [3:0] r_duty_shd;
    logic       r_pend;
    logic       r_pwm;
    logic       r_done;
    logic       w_seq_bad;
    logic       w_bound;
    logic       w_apply;
    logic       w_xfer;
    logic [3:0] w_duty_act_nxt;
    logic       w_pwm_nxt;
    logic       w_done_nxt;
    logic       w_ready;

`ifdef PWM_SEQ_CHECK_EN
    logic [3:0] r_prev_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_prev_cnt <= 4'd0;
        else      r_prev_cnt <= cnt;
    end

    assign w_seq_bad = (r_state == S_RUN) && (cnt != 4'(r_prev_cnt - 4'd1));
    assign seq_err   = (r_state == S_ERR);
    assign w_ready   = !r_pend && (r_state != S_ERR);
`else
    assign w_seq_bad = 1'b0;
    assign seq_err   = 1'b0;
    assign w_ready   = !r_pend;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (cnt == 4'hF) w_state_nxt = S_RUN;
`ifdef PWM_SEQ_CHECK_EN
            S_RUN:  if (w_seq_bad) w_state_nxt = S_ERR;
`endif
            default: w_state_nxt = r_state;
        endcase
    end

    // A new duty only reaches the comparator on the boundary edge, so a period is never split.
    always_comb begin
        w_bound        = (cnt == 4'hF) && !w_seq_bad
                         && ((r_state == S_IDLE) || (r_state == S_RUN));
        w_apply        = w_bound && r_pend;
        w_duty_act_nxt = w_apply ? r_duty_shd : r_duty_act;
        w_xfer         = duty_valid && w_ready;
        w_pwm_nxt      = 1'b0;
        w_done_nxt     = 1'b0;
        if ((r_state == S_RUN) && !w_seq_bad) begin
            w_pwm_nxt  = (cnt < w_duty_act_nxt);
            w_done_nxt = (cnt == 4'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty_act <= 4'd0;
            r_duty_shd <= 4'd0;
            r_pend     <= 1'b0;
            r_pwm      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_pwm      <= w_pwm_nxt;
            r_done     <= w_done_nxt;
            r_duty_act <= w_duty_act_nxt;
            if (w_apply) begin
                r_pend <= 1'b0;
            end else if (w_xfer) begin
                r_pend     <= 1'b1;
                r_duty_shd <= duty;
            end
        end
    end

    assign duty_ready  = w_ready;
    assign pwm_out     = r_pwm;
    assign period_done = r_done;
endmodule

// File: tb/tb_cnt_pwm_gen.sv
// Scoreboard bench for cnt_pwm_gen: queue-based period model, randomized duty requests.
module tb_cnt_pwm_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cnt = 4'd0;
    logic [3:0] duty = 4'd0;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_done;
    logic       seq_err;

    cnt_pwm_gen dut (
        .clk(clk), .rst(rst), .cnt(cnt), .duty(duty), .duty_valid(duty_valid),
        .duty_ready(duty_ready), .pwm_out(pwm_out), .period_done(period_done),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pwm;
        logic done;
        logic rdy;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    logic       m_run;
    logic       m_err;
    logic [3:0] m_act;
    logic [3:0] m_prev;
    logic [3:0] m_pend_q[$];

    logic [3:0] cv = 4'd0;
    int         hi_acc = 0;
    int         last_hi = -1;

    task automatic check(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_err  = 1'b0;
        m_act  = 4'd0;
        m_prev = 4'd0;
        m_pend_q.delete();
    endtask

    // One clock edge worth of behaviour, computed from the period/shadow rules.
    task automatic model_step();
        exp_t e;
        logic was_run;
        logic rdy;
        logic err_now;
        was_run = m_run;
        rdy     = (m_pend_q.size() == 0) && !m_err;
        err_now = 1'b0;
`ifdef PWM_SEQ_CHECK_EN
        if (m_run && !m_err && (cnt != 4'(m_prev - 4'd1))) err_now = 1'b1;
`endif
        m_prev = cnt;
        if (m_err || err_now) begin
            m_err = 1'b1;
            e = '{pwm: 1'b0, done: 1'b0, rdy: 1'b0, err: 1'b1};
        end else begin
            e.done = was_run && (cnt == 4'd0);
            if (cnt == 4'hF) begin
                if (m_pend_q.size() > 0) m_act = m_pend_q.pop_front();
                m_run = 1'b1;
            end
            if (duty_valid && rdy) m_pend_q.push_back(duty);
            e.pwm = was_run && (cnt < m_act);
            e.rdy = (m_pend_q.size() == 0);
            e.err = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("pwm_out", pwm_out, e.pwm);
                check("period_done", period_done, e.done);
                check("duty_ready", duty_ready, e.rdy);
                check("seq_err", seq_err, e.err);
                hi_acc += int'(pwm_out);
                if (period_done) begin
                    last_hi = hi_acc;
                    hi_acc  = 0;
                end
            end
        end
    end

    task automatic drive_cycle(input logic v, input logic [3:0] d, output logic acc);
        cnt        = cv;
        duty_valid = v;
        duty       = v ? d : 4'($urandom_range(0, 15));
        acc        = v && duty_ready;
        model_step();
        cv = cv - 4'd1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 4'd0, acc);
    endtask

    task automatic run_to(input logic [3:0] c);
        logic acc;
        for (int i = 0; i < 16 && cv != c; i++) drive_cycle(1'b0, 4'd0, acc);
    endtask

    task automatic send(input logic [3:0] d);
        logic acc;
        int   k;
        acc = 1'b0;
        for (k = 0; k < 40 && !acc; k++) drive_cycle(1'b1, d, acc);
        if (!acc) check("send_timeout", 1'b0, 1'b1);
    endtask

    initial begin : driver
        logic acc;
        logic rv;
        logic [3:0] rd;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pwm", pwm_out, 1'b0);
        check("rst_done", period_done, 1'b0);
        check("rst_ready", duty_ready, 1'b1);
        check("rst_seq_err", seq_err, 1'b0);
        rst = 1'b1;

        // free-running counter from 0, no duty request
        idle(40);

        // duty=4 mid-period
        run_to(4'd8);
        drive_cycle(1'b1, 4'd4, acc);
        check("accept_d4", acc, 1'b1);
        check("ready_low_after_xfer", duty_ready, 1'b0);
        idle(40);
        check_int("duty4_high_cycles", last_hi, 4);

        // duty=10 on the boundary cycle: old duty kept for one more period
        run_to(4'hF);
        drive_cycle(1'b1, 4'd10, acc);
        check("accept_d10", acc, 1'b1);
        idle(15);
        check_int("boundary_keeps_old", last_hi, 4);
        idle(16);
        check_int("duty10_high_cycles", last_hi, 10);

        // second request held while not ready
        run_to(4'd5);
        drive_cycle(1'b1, 4'd2, acc);
        send(4'd12);
        idle(32);
        check_int("held_duty12", last_hi, 12);

        // randomized requests held until accepted
        rv = 1'b0;
        rd = 4'd0;
        for (int i = 0; i < 500; i++) begin
            if (!rv && $urandom_range(0, 3) == 0) begin
                rv = 1'b1;
                rd = 4'($urandom_range(0, 15));
            end
            drive_cycle(rv, rd, acc);
            if (acc) rv = 1'b0;
        end
        idle(2);

        // asynchronous reset while the output is high
        send(4'd8);
        for (int k = 0; k < 64 && pwm_out !== 1'b1; k++) drive_cycle(1'b0, 4'd0, acc);
        check("pre_rst_pwm_high", pwm_out, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_pwm", pwm_out, 1'b0);
        check("async_rst_ready", duty_ready, 1'b1);
        model_reset();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{pwm: 1'b0, done: 1'b0, rdy: 1'b1, err: 1'b0});
            @(negedge clk);
            cv = cv - 4'd1;
        end
        rst = 1'b1;
        idle(40);
        send(4'd6);
        idle(40);
        check_int("post_rst_duty6", last_hi, 6);

        // count jump 9 -> 5
        run_to(4'd9);
        drive_cycle(1'b0, 4'd0, acc);
        cv = 4'd5;
        drive_cycle(1'b0, 4'd0, acc);
        drive_cycle(1'b1, 4'd3, acc);
        idle(20);
`ifdef PWM_SEQ_CHECK_EN
        check("seq_err_sticky", seq_err, 1'b1);
`else
        check("seq_err_tied_low", seq_err, 1'b0);
`endif
        @(posedge clk);
        #2;
        check_int("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
